// File: rtl/spi_master_if.sv
// Register bus shared with the GPIO block.
// The CPU side drives this bus. The SPI master answers it.
interface spi_master_if;
  logic [1:0] reg_addr;
  logic [7:0] reg_data_in;
  logic [7:0] reg_data_out;
  logic       reg_write;
  logic       reg_read;

  modport master (
    output reg_addr,
    output reg_data_in,
    output reg_write,
    output reg_read,
    input  reg_data_out
  );

  modport slave (
    input  reg_addr,
    input  reg_data_in,
    input  reg_write,
    input  reg_read,
    output reg_data_out
  );
endinterface

// File: rtl/spi_master.sv
// Byte-wide SPI master with cpol/cpha, 8-bit SCK divider and
// three active-low chip selects behind an 8-bit register bus.
module spi_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_miso,
  output logic        spi_mosi,
  output logic        spi_clk,
  output logic [2:0]  spi_cs,
  output logic        interrupt,
  spi_master_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    LAST
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] ctrl_q, ctrl_d;
  logic [7:0] div_q, div_d;
  logic [7:0] hc_q, hc_d;
  logic [3:0] ec_q, ec_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] rx_q, rx_d;
  logic       mosi_q, mosi_d;
  logic       sck_q, sck_d;
  logic [2:0] cs_q, cs_d;
  logic [2:0] cs_sel;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;
  logic       irq_q;
  logic       done_set;
  logic       busy;
  logic       hp_end;
  logic       cpha;
  logic       wr_data, wr_ctrl;
  logic       wr_div, wr_stat;
  logic       rd_data;
  logic [7:0] din;
  logic       cs_release;

  assign busy    = (state_q != IDLE);
  assign hp_end  = (hc_q == div_q);
  assign cpha    = ctrl_q[3];
  assign din     = bus.reg_data_in;
  assign wr_data = bus.reg_write
                && bus.reg_addr == 2'd0;
  assign wr_ctrl = bus.reg_write
                && bus.reg_addr == 2'd1;
  assign wr_div  = bus.reg_write
                && bus.reg_addr == 2'd2;
  assign wr_stat = bus.reg_write
                && bus.reg_addr == 2'd3;
  assign rd_data = bus.reg_read
                && bus.reg_addr == 2'd0;

  // A held CS is dropped when hold is cleared or the select moves.
  assign cs_release = wr_ctrl
                   && (!din[4]
                    || din[1:0] != ctrl_q[1:0]);

  always_comb begin
    case (ctrl_q[1:0])
      2'd0:    cs_sel = 3'b110;
      2'd1:    cs_sel = 3'b101;
      2'd2:    cs_sel = 3'b011;
      default: cs_sel = 3'b111;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    div_d    = div_q;
    hc_d     = hc_q;
    ec_d     = ec_q;
    tx_d     = tx_q;
    sh_d     = sh_q;
    rx_d     = rx_q;
    mosi_d   = mosi_q;
    sck_d    = sck_q;
    cs_d     = cs_q;
    done_set = 1'b0;

    if (wr_ctrl) begin
      if (busy) ctrl_d[5] = din[5];
      else      ctrl_d    = din[5:0];
    end
    if (wr_div && !busy) div_d = din;

    unique case (state_q)
      IDLE: begin
        sck_d = ctrl_d[2];
        if (cs_release) cs_d = 3'b111;
        if (wr_data) begin
          state_d = SETUP;
          hc_d    = '0;
          ec_d    = '0;
          tx_d    = din;
          sh_d    = '0;
          cs_d    = cs_sel;
          if (!cpha) mosi_d = din[7];
        end
      end
      SETUP: begin
        hc_d = hc_q + 8'd1;
        if (hp_end) begin
          hc_d    = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        hc_d = hc_q + 8'd1;
        if (hp_end) begin
          hc_d  = '0;
          sck_d = ~sck_q;
          ec_d  = ec_q + 4'd1;
          // ec_q even means this is an odd-numbered edge
          if (~ec_q[0] ^ cpha) begin
            sh_d = {sh_q[6:0], spi_miso};
          end else if (ec_q != 4'd15) begin
            mosi_d = cpha ? tx_q[7] : tx_q[6];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (ec_q == 4'd15) state_d = LAST;
        end
      end
      LAST: begin
        hc_d = hc_q + 8'd1;
        if (hp_end) begin
          hc_d     = '0;
          state_d  = IDLE;
          rx_d     = sh_q;
          done_set = 1'b1;
          if (!ctrl_q[4]) cs_d = 3'b111;
        end
      end
      default: state_d = IDLE;
    endcase

    done_d = done_set
          | (done_q
           & ~rd_data
           & ~(wr_stat & din[1]));
    ovr_d  = (wr_data & busy)
          | (ovr_q & ~(wr_stat & din[2]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q  <= 6'h03;
      div_q   <= 8'h03;
      hc_q    <= '0;
      ec_q    <= '0;
      tx_q    <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      mosi_q  <= 1'b0;
      sck_q   <= 1'b0;
      cs_q    <= 3'b111;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      div_q   <= div_d;
      hc_q    <= hc_d;
      ec_q    <= ec_d;
      tx_q    <= tx_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      mosi_q  <= mosi_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      irq_q   <= done_q & ctrl_q[5];
    end
  end

  always_comb begin
    unique case (bus.reg_addr)
      2'd0:    bus.reg_data_out = rx_q;
      2'd1:    bus.reg_data_out = {2'b00, ctrl_q};
      2'd2:    bus.reg_data_out = div_q;
      default: bus.reg_data_out = {5'b0, ovr_q,
                                   done_q, busy};
    endcase
  end

  assign spi_mosi  = mosi_q;
  assign spi_clk   = sck_q;
  assign spi_cs    = cs_q;
  assign interrupt = irq_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master.
// Covers modes 0/3, overrun, held CS, the done-clear race and mid-transfer reset.
module tb_spi_master;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_miso, spi_mosi;
  logic       spi_clk, interrupt;
  logic [2:0] spi_cs;
  logic       loopback = 1'b1;
  logic       miso_model = 1'b0;
  int         checks = 0;
  int         failures = 0;

  spi_master_if bus();

  assign spi_miso = loopback ? spi_mosi : miso_model;

  always #5 clk = ~clk;

  spi_master dut (
    .clk       (clk),
    .reset     (reset),
    .spi_miso  (spi_miso),
    .spi_mosi  (spi_mosi),
    .spi_clk   (spi_clk),
    .spi_cs    (spi_cs),
    .interrupt (interrupt),
    .bus       (bus)
  );

  task automatic wr(input logic [1:0] a,
                    input logic [7:0] d);
    bus.reg_addr    = a;
    bus.reg_data_in = d;
    bus.reg_write   = 1'b1;
    @(posedge clk); #1;
    bus.reg_write   = 1'b0;
    bus.reg_addr    = 2'd3;
  endtask

  task automatic peek(input logic [1:0] a,
                      output logic [7:0] v);
    bus.reg_addr = a;
    #1;
    v = bus.reg_data_out;
    bus.reg_addr = 2'd3;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (spi_cs !== 3'b111) begin
      failures++;
      $display("FAIL rst_cs got=%b exp=111", spi_cs);
    end
    checks++;
    if (spi_clk !== 1'b0 || spi_mosi !== 1'b0) begin
      failures++;
      $display("FAIL rst_pins got=%b%b exp=00", spi_clk, spi_mosi);
    end
    checks++;
    if (interrupt !== 1'b0) begin
      failures++;
      $display("FAIL rst_irq got=%b exp=0", interrupt);
    end
    peek(2'd1, v);
    checks++;
    if (v !== 8'h03) begin
      failures++;
      $display("FAIL rst_ctrl got=%h exp=03", v);
    end
    peek(2'd2, v);
    checks++;
    if (v !== 8'h03) begin
      failures++;
      $display("FAIL rst_div got=%h exp=03", v);
    end
    peek(2'd3, v);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL rst_status got=%h exp=00", v);
    end
    peek(2'd0, v);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL rst_rx got=%h exp=00", v);
    end
  endtask

  task automatic test_mode0();
    logic [7:0] st, v;
    logic prev;
    int cs_low, rises, t_done, t_irq;
    loopback = 1'b1;
    wr(2'd2, 8'h00);
    wr(2'd1, 8'h20);
    wr(2'd0, 8'hA5);
    cs_low = 0; rises = 0;
    t_done = -1; t_irq = -1;
    prev = spi_clk;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!spi_cs[0]) cs_low++;
      if (spi_clk && !prev) rises++;
      prev = spi_clk;
      peek(2'd3, st);
      if (st[1] && t_done < 0) t_done = i;
      if (interrupt && t_irq < 0) t_irq = i;
    end
    checks++;
    if (cs_low !== 18) begin
      failures++;
      $display("FAIL m0_cs_low got=%0d exp=18", cs_low);
    end
    checks++;
    if (rises !== 8) begin
      failures++;
      $display("FAIL m0_rises got=%0d exp=8", rises);
    end
    checks++;
    if (t_done !== 18) begin
      failures++;
      $display("FAIL m0_done_at got=%0d exp=18", t_done);
    end
    checks++;
    if (t_irq !== 19) begin
      failures++;
      $display("FAIL m0_irq_at got=%0d exp=19", t_irq);
    end
    peek(2'd0, v);
    checks++;
    if (v !== 8'hA5) begin
      failures++;
      $display("FAIL m0_rx got=%h exp=a5", v);
    end
    wr(2'd3, 8'h02);
    @(negedge clk);
    peek(2'd3, st);
    checks++;
    if (st[1] !== 1'b0 || interrupt !== 1'b1) begin
      failures++;
      $display("FAIL m0_w1c got=%b%b exp=01", st[1], interrupt);
    end
    @(negedge clk);
    checks++;
    if (interrupt !== 1'b0) begin
      failures++;
      $display("FAIL m0_irq_clr got=%b exp=0", interrupt);
    end
  endtask

  task automatic test_mode3();
    logic [7:0] st, v, mbyte, mdl;
    logic prev;
    int falls, t1, t2, t_done;
    mdl = 8'h3C;
    loopback = 1'b0;
    miso_model = 1'b0;
    wr(2'd2, 8'h03);
    wr(2'd1, 8'h0D);
    @(negedge clk);
    checks++;
    if (spi_clk !== 1'b1) begin
      failures++;
      $display("FAIL m3_idle_sck got=%b exp=1", spi_clk);
    end
    wr(2'd0, 8'hC3);
    prev = spi_clk;
    falls = 0; mbyte = 8'h00;
    t1 = -1; t2 = -1; t_done = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (spi_cs !== 3'b101) begin
          failures++;
          $display("FAIL m3_cs got=%b exp=101", spi_cs);
        end
      end
      if (!spi_clk && prev) begin
        mbyte = {mbyte[6:0], spi_mosi};
        if (falls < 8) miso_model = mdl[7-falls];
        if (falls == 0) t1 = i;
        if (falls == 1) t2 = i;
        falls++;
      end
      prev = spi_clk;
      peek(2'd3, st);
      if (st[1] && t_done < 0) t_done = i;
      if (t_done >= 0) break;
    end
    checks++;
    if (falls !== 8 || t2 - t1 !== 8) begin
      failures++;
      $display("FAIL m3_sck falls=%0d period=%0d exp=8/8", falls, t2 - t1);
    end
    checks++;
    if (mbyte !== 8'hC3) begin
      failures++;
      $display("FAIL m3_mosi got=%h exp=c3", mbyte);
    end
    checks++;
    if (t_done !== 72) begin
      failures++;
      $display("FAIL m3_len got=%0d exp=72", t_done);
    end
    peek(2'd0, v);
    checks++;
    if (v !== 8'h3C) begin
      failures++;
      $display("FAIL m3_rx got=%h exp=3c", v);
    end
    checks++;
    if (spi_clk !== 1'b1) begin
      failures++;
      $display("FAIL m3_rest_sck got=%b exp=1", spi_clk);
    end
    wr(2'd3, 8'h02);
    loopback = 1'b1;
  endtask

  task automatic test_overrun();
    logic [7:0] st, v, mbyte;
    logic prev;
    int rises;
    logic ok;
    wr(2'd1, 8'h20);
    wr(2'd0, 8'h11);
    wr(2'd0, 8'h22);
    wr(2'd1, 8'h1F);
    wr(2'd2, 8'h55);
    prev = spi_clk;
    rises = 0; mbyte = 8'h00; ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (spi_clk && !prev) begin
        mbyte = {mbyte[6:0], spi_mosi};
        rises++;
      end
      prev = spi_clk;
      peek(2'd3, st);
      if (st[1]) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ovr_wait got=timeout exp=done");
    end
    checks++;
    if (st[2] !== 1'b1) begin
      failures++;
      $display("FAIL ovr_flag got=%b exp=1", st[2]);
    end
    checks++;
    if (mbyte !== 8'h11 || rises !== 8) begin
      failures++;
      $display("FAIL ovr_mosi got=%h/%0d exp=11/8", mbyte, rises);
    end
    peek(2'd1, v);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL ovr_ctrl got=%h exp=00", v);
    end
    peek(2'd2, v);
    checks++;
    if (v !== 8'h03) begin
      failures++;
      $display("FAIL ovr_div got=%h exp=03", v);
    end
    peek(2'd0, v);
    checks++;
    if (v !== 8'h11) begin
      failures++;
      $display("FAIL ovr_rx got=%h exp=11", v);
    end
    wr(2'd3, 8'h04);
    peek(2'd3, v);
    checks++;
    if (v !== 8'h02) begin
      failures++;
      $display("FAIL ovr_w1c got=%h exp=02", v);
    end
    wr(2'd3, 8'h02);
  endtask

  task automatic test_hold_cs();
    logic [7:0] st, v;
    int cs_high;
    logic ok;
    wr(2'd2, 8'h00);
    wr(2'd1, 8'h12);
    wr(2'd0, 8'h5A);
    cs_high = 0; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (spi_cs[2]) cs_high++;
      peek(2'd3, st);
      if (!st[0]) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (spi_cs[2]) cs_high++;
    end
    checks++;
    if (spi_cs !== 3'b011) begin
      failures++;
      $display("FAIL hold_idle_cs got=%b exp=011", spi_cs);
    end
    wr(2'd0, 8'h96);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (spi_cs[2]) cs_high++;
      peek(2'd3, st);
      if (!st[0]) break;
      if (i == 59) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL hold_wait got=timeout exp=idle");
    end
    checks++;
    if (cs_high !== 0) begin
      failures++;
      $display("FAIL hold_cs_gap got=%0d exp=0", cs_high);
    end
    peek(2'd0, v);
    checks++;
    if (v !== 8'h96) begin
      failures++;
      $display("FAIL hold_rx got=%h exp=96", v);
    end
    wr(2'd1, 8'h02);
    @(negedge clk);
    checks++;
    if (spi_cs !== 3'b111) begin
      failures++;
      $display("FAIL hold_release got=%b exp=111", spi_cs);
    end
    wr(2'd3, 8'h02);
  endtask

  task automatic test_done_race();
    logic [7:0] st, v;
    wr(2'd0, 8'h77);
    repeat (17) @(posedge clk);
    #1;
    peek(2'd3, st);
    checks++;
    if (st[1:0] !== 2'b01) begin
      failures++;
      $display("FAIL race_pre got=%b exp=01", st[1:0]);
    end
    bus.reg_addr = 2'd0;
    bus.reg_read = 1'b1;
    @(posedge clk); #1;
    bus.reg_read = 1'b0;
    bus.reg_addr = 2'd3;
    @(negedge clk);
    peek(2'd3, st);
    checks++;
    if (st[1:0] !== 2'b10) begin
      failures++;
      $display("FAIL race_set_wins got=%b exp=10", st[1:0]);
    end
    bus.reg_addr = 2'd0;
    bus.reg_read = 1'b1;
    @(posedge clk); #1;
    bus.reg_read = 1'b0;
    bus.reg_addr = 2'd3;
    @(negedge clk);
    peek(2'd3, st);
    checks++;
    if (st[1] !== 1'b0) begin
      failures++;
      $display("FAIL race_clear got=%b exp=0", st[1]);
    end
    peek(2'd0, v);
    checks++;
    if (v !== 8'h77) begin
      failures++;
      $display("FAIL race_rx got=%h exp=77", v);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    logic prev;
    int tog;
    logic ok;
    wr(2'd2, 8'h01);
    wr(2'd1, 8'h01);
    wr(2'd0, 8'hE1);
    prev = spi_clk;
    tog = 0; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (spi_clk !== prev) tog++;
      prev = spi_clk;
      if (tog == 7) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || spi_cs !== 3'b101) begin
      failures++;
      $display("FAIL mid_pre got=%0d/%b exp=7/101", tog, spi_cs);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (spi_cs !== 3'b111) begin
      failures++;
      $display("FAIL mid_cs got=%b exp=111", spi_cs);
    end
    checks++;
    if (spi_clk !== 1'b0) begin
      failures++;
      $display("FAIL mid_sck got=%b exp=0", spi_clk);
    end
    peek(2'd3, v);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL mid_status got=%h exp=00", v);
    end
    peek(2'd0, v);
    checks++;
    if (v !== 8'h00) begin
      failures++;
      $display("FAIL mid_rx got=%h exp=00", v);
    end
    peek(2'd1, v);
    checks++;
    if (v !== 8'h03) begin
      failures++;
      $display("FAIL mid_ctrl got=%h exp=03", v);
    end
    peek(2'd2, v);
    checks++;
    if (v !== 8'h03) begin
      failures++;
      $display("FAIL mid_div got=%h exp=03", v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.reg_addr    = 2'd3;
    bus.reg_data_in = 8'h00;
    bus.reg_write   = 1'b0;
    bus.reg_read    = 1'b0;
    test_reset();
    test_mode0();
    test_mode3();
    test_overrun();
    test_hold_cs();
    test_done_race();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_master.md
# spi_master

Byte-wide SPI master controller that sequences the SPI pins routed through the GPIO pin-mux block. It generates `spi_clk`, `spi_mosi` and three active-low chip selects, and samples `spi_miso`. It sits on the same 8-bit register bus as the GPIO block, and its outputs feed the GPIO source selectors. The pin routing itself (src 2/3/4..6 and the miso source select) stays in the GPIO block.

## Interface
- Parameters: none; SCK divider width fixed at 8 bits.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `spi_miso`  in  1  serial data in, from the GPIO miso source mux.
- `spi_mosi`  out  1  serial data out; reset 0.
- `spi_clk`  out  1  SCK; reset 0 (= CPOL reset value).
- `spi_cs`  out  3  active-low selects; reset 3'b111.
- `interrupt`  out  1  `done & ie`; reset 0.
- `reg_addr`  in  2  register select.
- `reg_data_in`  in  8  write data.
- `reg_data_out`  out  8  read data, combinational from `reg_addr`.
- `reg_write`  in  1  one-cycle write strobe.
- `reg_read`  in  1  one-cycle read strobe; side effects only.

## Operation
- Reg 0 DATA:
  - Write while idle: load TX shifter, start a transfer.
  - Write while busy: ignored, sets `overrun`.
  - Read returns the RX byte. `reg_read` at addr 0 clears `done`.
- Reg 1 CTRL, reset 8'h03:
  - [1:0] cs select (0–2; 3 = none).
  - [2] cpol; [3] cpha; [4] hold_cs; [5] ie.
  - While busy, only [5] is writable; other bits keep their value.
- Reg 2 DIV, reset 8'h03: half-period = DIV+1 clocks. Write ignored while busy.
- Reg 3 STATUS, reset 0:
  - [0] busy, read-only.
  - [1] done, sticky.
  - [2] overrun, sticky.
  - Write 1 to [1] or [2] clears that bit.
- FSM states: IDLE, SETUP, SHIFT, LAST, with half-period counter `hc` and edge counter `ec` (0..15).
  - IDLE -> SETUP on accepted DATA write. Selected CS goes low. If cpha=0, MOSI is driven with TX[7].
  - SETUP lasts one half-period, then -> SHIFT.
  - SHIFT toggles `spi_clk` at every half-period end, 16 edges total, MSB first.
  - cpha=0: sample on odd edges (1st, 3rd, …); shift out on even edges, except the 16th.
  - cpha=1: shift out on odd edges; sample on even edges.
  - After the 16th edge -> LAST for one half-period; `spi_clk` rests at cpol.
  - LAST end -> IDLE. RX is updated and `done` set. CS deasserts unless hold_cs=1.
- With hold_cs=1, CS stays low in IDLE until CTRL is written with hold_cs=0 or a different select. Select 3 never asserts CS.
- In IDLE, `spi_clk` = cpol and follows CTRL writes the next cycle.
- `reset` at any time, including mid-transfer: all registers return to reset values next cycle. CS deasserts immediately; no partial RX update; done/overrun cleared.

## Timing
- DATA write at edge N: busy=1 and CS low from N+1.
- Transfer length = 18 × (DIV+1) clocks from N+1 to the cycle `done` reads 1. With DIV=0 that is 18 clocks.
- Completion cycle: busy is still 1, so a DATA write in that cycle is an overrun.
- The next DATA write is accepted one cycle after busy=0.
- Clearing `done` (read or W1C) in the same cycle it is set: set wins.
- `interrupt` is registered: it asserts the cycle after `done` sets, deasserts the cycle after clear or ie=0.
- Sampling occurs at the same clock edge as the SCK transition.

## Test plan
- Mode 0 loopback:
  - Stimulus: DIV=0, CTRL=8'h20, `spi_miso`=`spi_mosi`, write DATA=8'hA5.
  - Required: CS[0] low for 18 clocks; 8 SCK rising edges; RX=8'hA5; done=1 and interrupt=1 one clock later.
- Mode 3 with divider:
  - Stimulus: DIV=3, CTRL=8'h0D, MISO driven from model byte 8'h3C, write 8'hC3.
  - Required: CS[1] low; SCK idles high with 8-clock period; MOSI bits 1,1,0,0,0,0,1,1 on falling edges; RX=8'h3C after 72 clocks.
- Overrun:
  - Stimulus: write 8'h11 then, while busy, 8'h22.
  - Required: overrun=1, MOSI stream = 8'h11, CTRL bits [4:0] unchanged.
  - Then W1C 8'h04: overrun=0.
- Hold CS:
  - Stimulus: CTRL=8'h12, two back-to-back transfers.
  - Required: CS[2] stays low between them.
  - Then write CTRL=8'h02: CS[2] high next cycle.
- Reset mid-transfer:
  - Stimulus: assert `reset` at edge 7 of a transfer.
  - Required: next cycle CS=3'b111, SCK=0, busy=0, RX=0, CTRL=8'h03, DIV=8'h03.
- Done clear race:
  - Stimulus: `reg_read` at addr 0 in the completion cycle.
  - Required: done remains 1; a read one cycle later clears it.
